memory_pipeline_unit: RTL and testbench
=======================================

// Module: memory_pipeline_unit
// PURPOSE
//  Memory-stage controller register. Sits between execute and writeback.
//  - Latches the execute-stage instruction and PC.
//  - Decodes rn/rt/opcode through idecoder.
//  - Drives the data-memory request handshake for LDR/STR.
//  - Stalls upstream while memory is not ready, and feeds NOP bubbles to writeback during a stall.
// PARAMETERS
//  PC_W        7            width of the pc_in/pc_out stage PC
//  MEM_TIMEOUT 16           wait cycles before fault (used only with MEM_STAGE_TIMEOUT_EN)
// PORTS
//  clk        in   1     clock; all state updates on posedge
//  rst        in   1     synchronous reset, active-high
//  instr_in   in   32    instruction from execute stage
//  pc_in      in   PC_W  PC from execute stage
//  flush      in   1     squash held instruction (branch taken upstream)
//  mem_ready  in   1     data memory accepts/completes the access this cycle
//  instr_out  out  32    instruction to writeback stage (NOP during a bubble)
//  pc_out     out  PC_W  held PC to writeback stage
//  rn         out  4     base register of held instruction
//  rt         out  4     destination/source register of held instruction
//  opcode     out  7     idecoder opcode of held instruction
//  mem_req    out  1     data memory request
//  mem_we     out  1     1 = store, 0 = load; valid while mem_req=1
//  sel_load   out  1     writeback selects memory read data
//  stall      out  1     freeze execute and earlier stages
//  mem_fault  out  1     sticky access timeout (0 when feature compiled out)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): instr_reg=NOP (32'hE320F000), pc_reg=0, state=IDLE, wait_cnt=0, mem_fault=0.
//    Consequently mem_req=mem_we=sel_load=stall=0 and instr_out=NOP.
//  - Memory decode on instr_reg (combinational):
//    is_mem = instr_reg[27:26]==2'b01; is_load = is_mem & instr_reg[20].
//  - mem_req = is_mem & (state!=FAULT).
//  - mem_we = is_mem & ~instr_reg[20]; sel_load = is_load.
//  - stall = (mem_req & ~mem_ready) | (state==FAULT).
//  - instr_out = stall ? NOP : instr_reg; pc_out = pc_reg always.
//  - Register update priority per posedge: rst > flush > stall > load.
//    - flush: instr_reg<=NOP, pc_reg<=0, state<=IDLE, wait_cnt<=0. Aborts any pending access; mem_fault unchanged.
//    - stall: instr_reg and pc_reg hold; instr_in is ignored.
//    - otherwise: instr_reg<=instr_in, pc_reg<=pc_in.
//  - Latency: one cycle instr_in -> instr_out when no stall.
//  - FSM:
//    - IDLE: on mem_req & ~mem_ready -> WAIT, wait_cnt<=1. mem_req & mem_ready completes in 0 wait cycles and stays IDLE.
//    - WAIT: on mem_ready -> IDLE, wait_cnt<=0 (stall drops in the same cycle); else wait_cnt++.
//    - FAULT: mem_req=0, stall=1; leaves only on flush (-> IDLE) or rst.
//  - Back-to-back memory instructions: the next access starts in the cycle after completion, with no extra bubble.
//  - flush and mem_ready in the same cycle: flush wins; the access is treated as aborted.
// CONFIGURATION
//  MEM_STAGE_TIMEOUT_EN defined:
//   - wait_cnt width $clog2(MEM_TIMEOUT+1).
//   - In WAIT, if ~mem_ready and wait_cnt==MEM_TIMEOUT: state<=FAULT, mem_fault<=1.
//   - mem_fault clears only on rst.
//  Not defined: no counter and no FAULT state; WAIT lasts until mem_ready; mem_fault tied 0.
// STRUCTURE
//  Package pipeline_pkg:
//   - NOP_INSTR = 32'hE320F000.
//   - typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_FAULT} mem_state_t.
//   - Field constants: LS_CLASS_HI=27, LS_CLASS_LO=26, LS_L_BIT=20.
//  Sub-modules: instantiate the existing idecoder (rn, rd->rt, opcode); no new sub-module.
// TESTING
//  1. Reset: hold rst=1 for 2 cycles -> instr_out=E320F000, pc_out=0, mem_req=0, stall=0, mem_fault=0.
//  2. ADD E0812003, pc 5 -> next cycle instr_out=E0812003, pc_out=5, mem_req=0, rt=2.
//  3. LDR E5912000, mem_ready=1 -> mem_req=1, mem_we=0, sel_load=1, stall=0, rn=1, rt=2.
//  4. STR E5812000, mem_ready low 3 cycles -> mem_we=1, stall=1 and instr_out=NOP for 3 cycles,
//     instr_in changes ignored; 4th cycle passes the STR, stall=0.
//  5. LDR waiting, then flush=1 -> next cycle instr_out=NOP, mem_req=0, state IDLE, pipeline resumes.
//  6. With MEM_STAGE_TIMEOUT_EN, mem_ready held 0 -> after 16 wait cycles mem_fault=1, mem_req=0, stall=1;
//     flush restores IDLE with mem_fault still 1.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the memory pipeline stage: NOP encoding,
// memory-stage FSM states and load/store field positions.
package pipeline_pkg;

  // Architectural NOP used for reset, flush and stall bubbles.
  localparam logic [31:0] NOP_INSTR = 32'hE320F000;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_FAULT
  } mem_state_t;

  // Load/store class field and L (load) bit positions.
  localparam int LS_CLASS_HI = 27;
  localparam int LS_CLASS_LO = 26;
  localparam int LS_L_BIT    = 20;

endpackage

// File: rtl/idecoder.sv
// Instruction field decoder: base register, destination register and a
// 7-bit opcode made of the class and operation fields.
module idecoder (
  input  logic [31:0] instr,
  output logic [3:0]  rn,
  output logic [3:0]  rd,
  output logic [6:0]  opcode
);

  // Bits not needed by this decoder; folded so they are visibly consumed.
  logic unused_bits;

  assign rn          = instr[19:16];
  assign rd          = instr[15:12];
  assign opcode      = instr[27:21];
  assign unused_bits = ^{instr[31:28], instr[20], instr[11:0]};

endmodule

// File: rtl/memory_pipeline_unit.sv
// Memory-stage pipeline register and data-memory handshake controller.
// Optional feature: define MEM_STAGE_TIMEOUT_EN to add an access timeout
// that moves the stage into a sticky FAULT condition.
//
// Handshake: mem_req is a level request held (with the instruction frozen)
// until a cycle where mem_ready=1; that cycle completes the access and the
// next instruction is latched at the same edge. flush aborts any access.
module memory_pipeline_unit
  import pipeline_pkg::*;
#(
  parameter int PC_W        = 7,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr_in,
  input  logic [PC_W-1:0] pc_in,
  input  logic            flush,
  input  logic            mem_ready,
  output logic [31:0]     instr_out,
  output logic [PC_W-1:0] pc_out,
  output logic [3:0]      rn,
  output logic [3:0]      rt,
  output logic [6:0]      opcode,
  output logic            mem_req,
  output logic            mem_we,
  output logic            sel_load,
  output logic            stall,
  output logic            mem_fault,
  output mem_state_t      state_dbg
);

  logic [31:0]     instr_reg;
  logic [PC_W-1:0] pc_reg;
  mem_state_t      state;
  logic            is_mem;
  logic            is_load;

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  // Timeout length only matters when the timeout feature is built in.
  localparam int unused_timeout = MEM_TIMEOUT;
`endif

  idecoder u_idecoder (
    .instr  (instr_reg),
    .rn     (rn),
    .rd     (rt),
    .opcode (opcode)
  );

  // Memory-class decode of the held instruction and handshake outputs.
  always_comb begin
    is_mem    = (instr_reg[LS_CLASS_HI:LS_CLASS_LO] == 2'b01);
    is_load   = is_mem & instr_reg[LS_L_BIT];
    mem_req   = is_mem & (state != MEM_FAULT);
    mem_we    = is_mem & ~instr_reg[LS_L_BIT];
    sel_load  = is_load;
    stall     = (mem_req & ~mem_ready) | (state == MEM_FAULT);
    instr_out = stall ? NOP_INSTR : instr_reg;
    pc_out    = pc_reg;
    state_dbg = state;
  end

`ifndef MEM_STAGE_TIMEOUT_EN
  assign mem_fault = 1'b0;
`endif

  // Stage register and access FSM; priority rst > flush > stall > load.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_reg <= NOP_INSTR;
      pc_reg    <= '0;
      state     <= MEM_IDLE;
`ifdef MEM_STAGE_TIMEOUT_EN
      wait_cnt  <= '0;
      mem_fault <= 1'b0;
`endif
    end else if (flush) begin
      instr_reg <= NOP_INSTR;
      pc_reg    <= '0;
      state     <= MEM_IDLE;
`ifdef MEM_STAGE_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      if (!stall) begin
        instr_reg <= instr_in;
        pc_reg    <= pc_in;
      end
      case (state)
        MEM_IDLE: begin
          if (mem_req && !mem_ready) begin
            state <= MEM_WAIT;
`ifdef MEM_STAGE_TIMEOUT_EN
            wait_cnt <= CNT_W'(1);
`endif
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state <= MEM_IDLE;
`ifdef MEM_STAGE_TIMEOUT_EN
            wait_cnt <= '0;
          end else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
            state     <= MEM_FAULT;
            mem_fault <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
`endif
          end
        end
        MEM_FAULT: state <= MEM_FAULT;
        default:   state <= MEM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_pipeline_unit.sv
// Bench for memory_pipeline_unit: directed vectors, a cycle-level
// behavioural model compared on every negedge, and literal spot checks.
module tb_memory_pipeline_unit;
  import pipeline_pkg::*;

  localparam int PC_W        = 7;
  localparam int MEM_TIMEOUT = 16;
  localparam logic [31:0] NOP  = 32'hE320F000;
  localparam logic [31:0] ADD  = 32'hE0812003;
  localparam logic [31:0] LDR  = 32'hE5912000;
  localparam logic [31:0] STR  = 32'hE5812000;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     instr_in;
  logic [PC_W-1:0] pc_in;
  logic            flush;
  logic            mem_ready;
  logic [31:0]     instr_out;
  logic [PC_W-1:0] pc_out;
  logic [3:0]      rn, rt;
  logic [6:0]      opcode;
  logic            mem_req, mem_we, sel_load, stall, mem_fault;
  mem_state_t      state_dbg;

  always #5 clk = ~clk;

  memory_pipeline_unit #(.PC_W(PC_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .instr_in  (instr_in),
    .pc_in     (pc_in),
    .flush     (flush),
    .mem_ready (mem_ready),
    .instr_out (instr_out),
    .pc_out    (pc_out),
    .rn        (rn),
    .rt        (rt),
    .opcode    (opcode),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .sel_load  (sel_load),
    .stall     (stall),
    .mem_fault (mem_fault),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Held instruction/PC, count of consecutive unanswered request cycles,
  // and whether the stage is in the timed-out condition.
  logic [31:0]     m_instr;
  logic [PC_W-1:0] m_pc;
  int              m_waits;
  bit              m_faulted;
  bit              m_fault_flag;
  bit              m_valid = 1'b0;
  logic            m_req_now, m_stall_now;

  always @(posedge clk) begin
    m_req_now   = (m_instr[27:26] == 2'b01) && !m_faulted;
    m_stall_now = (m_req_now && !mem_ready) || m_faulted;
    if (rst) begin
      m_instr      <= NOP;
      m_pc         <= '0;
      m_waits      <= 0;
      m_faulted    <= 1'b0;
      m_fault_flag <= 1'b0;
      m_valid      <= 1'b1;
    end else if (flush) begin
      m_instr   <= NOP;
      m_pc      <= '0;
      m_waits   <= 0;
      m_faulted <= 1'b0;
    end else begin
      if (m_req_now && !mem_ready) begin
`ifdef MEM_STAGE_TIMEOUT_EN
        if (m_waits == MEM_TIMEOUT) begin
          m_faulted    <= 1'b1;
          m_fault_flag <= 1'b1;
        end else begin
          m_waits <= m_waits + 1;
        end
`else
        m_waits <= m_waits + 1;
`endif
      end else if (!m_faulted) begin
        m_waits <= 0;
      end
      if (!m_stall_now) begin
        m_instr <= instr_in;
        m_pc    <= pc_in;
      end
    end
  end

  // Compare every cycle once the model has seen reset.
  logic e_mem, e_req, e_stall;
  always @(negedge clk) begin
    if (m_valid) begin
      e_mem   = (m_instr[27:26] == 2'b01);
      e_req   = e_mem && !m_faulted;
      e_stall = (e_req && !mem_ready) || m_faulted;
      check("m_instr_out", instr_out, e_stall ? NOP : m_instr);
      check("m_pc_out",    32'(pc_out),   32'(m_pc));
      check("m_mem_req",   32'(mem_req),  32'(e_req));
      check("m_mem_we",    32'(mem_we),   32'(e_mem && !m_instr[20]));
      check("m_sel_load",  32'(sel_load), 32'(e_mem && m_instr[20]));
      check("m_stall",     32'(stall),    32'(e_stall));
      check("m_mem_fault", 32'(mem_fault), 32'(m_fault_flag));
      check("m_rn",        32'(rn),       32'(m_instr[19:16]));
      check("m_rt",        32'(rt),       32'(m_instr[15:12]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] ins, input logic [PC_W-1:0] pc,
                       input logic fl, input logic rdy);
    instr_in  = ins;
    pc_in     = pc;
    flush     = fl;
    mem_ready = rdy;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    drive(NOP, 0, 1'b0, 1'b0);
    tick();
    tick();

    // 1. reset state
    check("rst_instr_out", instr_out, 32'hE320F000);
    check("rst_pc_out",    32'(pc_out), 32'd0);
    check("rst_mem_req",   32'(mem_req), 32'd0);
    check("rst_stall",     32'(stall), 32'd0);
    check("rst_mem_fault", 32'(mem_fault), 32'd0);
    rst = 1'b0;

    // 2. ADD passes with one-cycle latency
    drive(ADD, 7'd5, 1'b0, 1'b1);
    tick();
    drive(LDR, 7'd6, 1'b0, 1'b1);
    check("add_instr_out", instr_out, 32'hE0812003);
    check("add_pc_out",    32'(pc_out), 32'd5);
    check("add_mem_req",   32'(mem_req), 32'd0);
    check("add_rt",        32'(rt), 32'd2);
    tick();

    // 3. LDR completes immediately; STR follows back-to-back
    drive(STR, 7'd7, 1'b0, 1'b1);
    check("ldr_mem_req",  32'(mem_req), 32'd1);
    check("ldr_mem_we",   32'(mem_we), 32'd0);
    check("ldr_sel_load", 32'(sel_load), 32'd1);
    check("ldr_stall",    32'(stall), 32'd0);
    check("ldr_rn",       32'(rn), 32'd1);
    check("ldr_rt",       32'(rt), 32'd2);
    tick();

    // 4. STR with memory not ready for 3 cycles; upstream changes ignored
    for (int i = 0; i < 3; i++) begin
      drive(ADD, 7'(20 + i), 1'b0, 1'b0);
      check("str_wait_stall",  32'(stall), 32'd1);
      check("str_wait_instr",  instr_out, 32'hE320F000);
      check("str_wait_we",     32'(mem_we), 32'd1);
      check("str_wait_pc",     32'(pc_out), 32'd7);
      tick();
    end
    drive(ADD, 7'd8, 1'b0, 1'b1);
    check("str_done_stall", 32'(stall), 32'd0);
    check("str_done_instr", instr_out, 32'hE5812000);
    tick();
    drive(LDR, 7'd9, 1'b0, 1'b1);
    check("after_str_instr", instr_out, 32'hE0812003);
    check("after_str_pc",    32'(pc_out), 32'd8);
    tick();

    // 5. LDR waiting, then flush together with mem_ready (flush wins)
    drive(ADD, 7'd10, 1'b0, 1'b0);
    check("flush_pre_stall", 32'(stall), 32'd1);
    tick();
    check("flush_pre_state", 32'(state_dbg), 32'(MEM_WAIT));
    drive(ADD, 7'd10, 1'b1, 1'b1);
    tick();
    drive(ADD, 7'd10, 1'b0, 1'b0);
    check("flush_instr_out", instr_out, 32'hE320F000);
    check("flush_mem_req",   32'(mem_req), 32'd0);
    check("flush_state",     32'(state_dbg), 32'(MEM_IDLE));
    check("flush_pc_out",    32'(pc_out), 32'd0);
    tick();
    drive(LDR, 7'd11, 1'b0, 1'b1);
    check("resume_instr", instr_out, 32'hE0812003);
    check("resume_pc",    32'(pc_out), 32'd10);
    tick();

    // 6. memory never answers: 16 wait cycles then timeout
    drive(NOP, 7'd12, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) tick();
    check("to_before_fault", 32'(mem_fault), 32'd0);
    check("to_before_req",   32'(mem_req), 32'd1);
    tick();
`ifdef MEM_STAGE_TIMEOUT_EN
    check("to_fault",       32'(mem_fault), 32'd1);
    check("to_fault_req",   32'(mem_req), 32'd0);
    check("to_fault_stall", 32'(stall), 32'd1);
    check("to_fault_state", 32'(state_dbg), 32'(MEM_FAULT));
    drive(NOP, 7'd12, 1'b1, 1'b0);
    tick();
    drive(NOP, 7'd12, 1'b0, 1'b0);
    check("to_flush_state", 32'(state_dbg), 32'(MEM_IDLE));
    check("to_flush_fault", 32'(mem_fault), 32'd1);
    check("to_flush_stall", 32'(stall), 32'd0);
`else
    for (int i = 0; i < 4; i++) tick();
    check("nto_fault", 32'(mem_fault), 32'd0);
    check("nto_stall", 32'(stall), 32'd1);
    check("nto_state", 32'(state_dbg), 32'(MEM_WAIT));
    drive(NOP, 7'd12, 1'b0, 1'b1);
    check("nto_release_stall", 32'(stall), 32'd0);
    tick();
    check("nto_release_pc", 32'(pc_out), 32'd12);
`endif
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
